// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-requester round-robin front end for a single-port SRAM wrapper.
//   A request is accepted in IDLE, the SRAM strobes are held for
//   ACC_CYCLES cycles in ACCESS, and a one-cycle response is returned
//   to the granted requester in RESP.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   mN_req_valid/ready         request handshake (ready only in IDLE)
//   mN_req_addr/wdata/we/wmask request payload, latched on grant
//   mN_resp_valid              one-cycle completion pulse
//   mN_resp_rdata              read data of the requester's last read
//   io_sram_*                  strobes/address/data to the ram wrapper
module sram_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 32,
    parameter int ACC_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_req_addr,
    input  logic [DATA_W-1:0]   m0_req_wdata,
    input  logic                m0_req_we,
    input  logic [DATA_W/8-1:0] m0_req_wmask,
    output logic                m0_resp_valid,
    output logic [DATA_W-1:0]   m0_resp_rdata,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_req_addr,
    input  logic [DATA_W-1:0]   m1_req_wdata,
    input  logic                m1_req_we,
    input  logic [DATA_W/8-1:0] m1_req_wmask,
    output logic                m1_resp_valid,
    output logic [DATA_W-1:0]   m1_resp_rdata,

    output logic [ADDR_W-1:0]   io_sram_addr,
    output logic [DATA_W-1:0]   io_sram_din,
    input  logic [DATA_W-1:0]   io_sram_dout,
    output logic                io_sram_en,
    output logic                io_sram_re,
    output logic                io_sram_we,
    output logic [DATA_W/8-1:0] io_sram_wmask
);

    localparam int         MASK_W   = DATA_W / 8;
    localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                last_grant;
    logic                owner;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                grant_any;
    logic                winner;

    // Round-robin pick: on contention the requester not granted last wins,
    // a lone requester wins regardless of history.
    always_comb begin
        grant_any = 1'b0;
        winner    = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            grant_any = 1'b1;
            winner    = ~last_grant;
        end else if (m0_req_valid) begin
            grant_any = 1'b1;
            winner    = 1'b0;
        end else if (m1_req_valid) begin
            grant_any = 1'b1;
            winner    = 1'b1;
        end
    end

    // Next state and ready; ready is gated by rst_n so nothing is granted
    // while reset is held.
    always_comb begin
        state_nxt    = state;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && rst_n) begin
                    state_nxt    = ACCESS;
                    m0_req_ready = ~winner;
                    m1_req_ready = winner;
                end
            end
            ACCESS: begin
                if (cnt == ACC_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, access counter, request latch and per-requester read data.
    // The counter saturates at the last access cycle rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            wmask_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cnt        <= 4'd0;
                        last_grant <= winner;
                        owner      <= winner;
                        addr_q     <= winner ? m1_req_addr  : m0_req_addr;
                        wdata_q    <= winner ? m1_req_wdata : m0_req_wdata;
                        we_q       <= winner ? m1_req_we    : m0_req_we;
                        wmask_q    <= winner ? m1_req_wmask : m0_req_wmask;
                    end
                end
                ACCESS: begin
                    if (cnt == ACC_LAST) begin
                        if (!we_q) begin
                            if (owner) begin
                                rdata1_q <= io_sram_dout;
                            end else begin
                                rdata0_q <= io_sram_dout;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_sram_en    = (state == ACCESS);
    assign io_sram_re    = io_sram_en & ~we_q;
    assign io_sram_we    = io_sram_en & we_q;
    assign io_sram_wmask = io_sram_we ? wmask_q : '0;
    assign io_sram_addr  = addr_q;
    assign io_sram_din   = wdata_q;

    assign m0_resp_valid = (state == RESP) && !owner;
    assign m1_resp_valid = (state == RESP) && owner;
    assign m0_resp_rdata = rdata0_q;
    assign m1_resp_rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed bench for sram_arbiter (default parameters, ACC_CYCLES=2).
//   A transaction-timeline model predicts every output each cycle; logs of
//   observed grants, accesses and responses are checked against
//   hand-computed literals after each scenario.
module tb_sram_arbiter;

    localparam int ACC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m1_req_valid;
    logic        m0_req_ready, m1_req_ready;
    logic [19:0] m0_req_addr, m1_req_addr;
    logic [31:0] m0_req_wdata, m1_req_wdata;
    logic        m0_req_we, m1_req_we;
    logic [3:0]  m0_req_wmask, m1_req_wmask;
    logic        m0_resp_valid, m1_resp_valid;
    logic [31:0] m0_resp_rdata, m1_resp_rdata;
    logic [19:0] io_sram_addr;
    logic [31:0] io_sram_din;
    logic [31:0] sram_dout;
    logic        io_sram_en, io_sram_re, io_sram_we;
    logic [3:0]  io_sram_wmask;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {int cyc; int id;} grant_t;
    typedef struct {int cyc; int id; logic [31:0] rdata;} resp_t;
    typedef struct {int cyc; logic [19:0] addr; logic [31:0] din; logic re; logic we; logic [3:0] wmask;} acc_t;
    grant_t grants[$];
    resp_t  resps[$];
    acc_t   accs[$];

    sram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_req_we(m0_req_we), .m0_req_wmask(m0_req_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_rdata(m0_resp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_req_we(m1_req_we), .m1_req_wmask(m1_req_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata),
        .io_sram_addr(io_sram_addr), .io_sram_din(io_sram_din),
        .io_sram_dout(sram_dout), .io_sram_en(io_sram_en),
        .io_sram_re(io_sram_re), .io_sram_we(io_sram_we),
        .io_sram_wmask(io_sram_wmask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic v, input logic we,
                                 input logic [19:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask);
        if (port == 0) begin
            m0_req_valid = v; m0_req_we = we; m0_req_addr = addr;
            m0_req_wdata = wdata; m0_req_wmask = mask;
        end else begin
            m1_req_valid = v; m1_req_we = we; m1_req_addr = addr;
            m1_req_wdata = wdata; m1_req_wmask = mask;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a transaction is a timeline anchored at its grant cycle g.
    // Strobes at g+1..g+ACC, response at g+ACC+1, idle again at g+ACC+2.
    bit          active = 1'b0;
    int          g_cyc = 0;
    int          owner = 0;
    int          m_last = 1;
    logic [19:0] m_addr = '0;
    logic [31:0] m_din = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_wmask = '0;
    logic [31:0] m_rd0 = '0;
    logic [31:0] m_rd1 = '0;
    int          age;
    int          win;
    bit          any_v;
    bit          e_r0, e_r1, e_en, e_rv0, e_rv1;

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            age   = cyc - g_cyc;
            any_v = m0_req_valid || m1_req_valid;
            if (m0_req_valid && m1_req_valid) win = 1 - m_last;
            else if (m0_req_valid)            win = 0;
            else                              win = 1;
            e_r0  = rst_n && !active && any_v && (win == 0);
            e_r1  = rst_n && !active && any_v && (win == 1);
            e_en  = active && age >= 1 && age <= ACC;
            e_rv0 = active && age == ACC + 1 && owner == 0;
            e_rv1 = active && age == ACC + 1 && owner == 1;

            checkOutput("m0_req_ready", 64'(m0_req_ready), 64'(e_r0));
            checkOutput("m1_req_ready", 64'(m1_req_ready), 64'(e_r1));
            checkOutput("io_sram_en", 64'(io_sram_en), 64'(e_en));
            checkOutput("io_sram_re", 64'(io_sram_re), 64'(e_en && !m_we));
            checkOutput("io_sram_we", 64'(io_sram_we), 64'(e_en && m_we));
            checkOutput("io_sram_wmask", 64'(io_sram_wmask), 64'((e_en && m_we) ? m_wmask : 4'h0));
            checkOutput("io_sram_addr", 64'(io_sram_addr), 64'(m_addr));
            checkOutput("io_sram_din", 64'(io_sram_din), 64'(m_din));
            checkOutput("m0_resp_valid", 64'(m0_resp_valid), 64'(e_rv0));
            checkOutput("m1_resp_valid", 64'(m1_resp_valid), 64'(e_rv1));
            checkOutput("m0_resp_rdata", 64'(m0_resp_rdata), 64'(m_rd0));
            checkOutput("m1_resp_rdata", 64'(m1_resp_rdata), 64'(m_rd1));

            if (m0_req_ready) grants.push_back('{cyc, 0});
            if (m1_req_ready) grants.push_back('{cyc, 1});
            if (m0_resp_valid) resps.push_back('{cyc, 0, m0_resp_rdata});
            if (m1_resp_valid) resps.push_back('{cyc, 1, m1_resp_rdata});
            if (io_sram_en) accs.push_back('{cyc, io_sram_addr, io_sram_din, io_sram_re, io_sram_we, io_sram_wmask});

            // Advance the model to what the coming rising edge produces.
            if (!rst_n) begin
                active = 1'b0; m_last = 1; m_addr = '0; m_din = '0;
                m_we = 1'b0; m_wmask = '0; m_rd0 = '0; m_rd1 = '0;
            end else begin
                if (active && age == ACC && !m_we) begin
                    if (owner == 0) m_rd0 = sram_dout;
                    else            m_rd1 = sram_dout;
                end
                if (active && age == ACC + 1) begin
                    active = 1'b0;
                end else if (!active && any_v) begin
                    active = 1'b1; g_cyc = cyc; owner = win; m_last = win;
                    m_addr  = (win == 0) ? m0_req_addr  : m1_req_addr;
                    m_din   = (win == 0) ? m0_req_wdata : m1_req_wdata;
                    m_we    = (win == 0) ? m0_req_we    : m1_req_we;
                    m_wmask = (win == 0) ? m0_req_wmask : m1_req_wmask;
                end
            end
            cyc++;
        end
    end

    int g0, r0, a0, g1, n1;

    initial begin : stimulus
        rst_n = 1'b0;
        sram_dout = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(3);
        checkOutput("reset_en", 64'(io_sram_en), 64'h0);
        checkOutput("reset_addr", 64'(io_sram_addr), 64'h0);
        checkOutput("reset_rdata0", 64'(m0_resp_rdata), 64'h0);

        // Single read from m0
        rst_n = 1'b1;
        sram_dout = 32'hDEADBEEF;
        g0 = grants.size(); r0 = resps.size(); a0 = accs.size();
        applyStimulus(0, 1'b1, 1'b0, 20'h00010, 32'h0, 4'h0);
        step(1);
        applyStimulus(0, 1'b0, 1'b0, 20'h00010, 32'h0, 4'h0);
        step(5);
        checkOutput("t1_grant_cnt", 64'(grants.size() - g0), 64'd1);
        checkOutput("t1_grant_id", 64'(grants[g0].id), 64'd0);
        checkOutput("t1_acc_cnt", 64'(accs.size() - a0), 64'd2);
        checkOutput("t1_acc_start", 64'(accs[a0].cyc - grants[g0].cyc), 64'd1);
        checkOutput("t1_acc_re", 64'(accs[a0].re & accs[a0+1].re), 64'd1);
        checkOutput("t1_acc_addr", 64'(accs[a0].addr), 64'h10);
        checkOutput("t1_resp_cnt", 64'(resps.size() - r0), 64'd1);
        checkOutput("t1_resp_id", 64'(resps[r0].id), 64'd0);
        checkOutput("t1_resp_rdata", 64'(resps[r0].rdata), 64'hDEADBEEF);
        checkOutput("t1_latency", 64'(resps[r0].cyc - grants[g0].cyc), 64'd3);
        checkOutput("t1_m1_rdata", 64'(m1_resp_rdata), 64'h0);

        // Single write from m1; m1 read data must stay untouched
        sram_dout = 32'hCAFEF00D;
        g0 = grants.size(); r0 = resps.size(); a0 = accs.size();
        applyStimulus(1, 1'b1, 1'b1, 20'h00004, 32'h12345678, 4'b0011);
        step(1);
        applyStimulus(1, 1'b0, 1'b0, 20'h00004, 32'h12345678, 4'b0011);
        step(5);
        checkOutput("t2_grant_id", 64'(grants[g0].id), 64'd1);
        checkOutput("t2_acc_cnt", 64'(accs.size() - a0), 64'd2);
        for (int k = 0; k < 2; k++) begin
            checkOutput("t2_acc_we", 64'({accs[a0+k].we, accs[a0+k].re}), 64'b10);
            checkOutput("t2_acc_wmask", 64'(accs[a0+k].wmask), 64'b0011);
            checkOutput("t2_acc_din", 64'(accs[a0+k].din), 64'h12345678);
        end
        checkOutput("t2_resp_id", 64'(resps[r0].id), 64'd1);
        checkOutput("t2_resp_rdata", 64'(resps[r0].rdata), 64'h0);

        // Contention from reset release: m0, m1, m0, m1 every 4 cycles
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        sram_dout = 32'h0BADF00D;
        g0 = grants.size();
        applyStimulus(0, 1'b1, 1'b0, 20'h00020, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b1, 20'h00030, 32'hAAAA5555, 4'hF);
        step(13);
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(6);
        checkOutput("t3_grant_cnt", 64'(grants.size() - g0), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_grant_order", 64'(grants[g0+k].id), 64'(k % 2));
            if (k > 0)
                checkOutput("t3_spacing", 64'(grants[g0+k].cyc - grants[g0+k-1].cyc), 64'd4);
        end

        // Back-to-back reads from m0 alone
        g0 = grants.size();
        applyStimulus(0, 1'b1, 1'b0, 20'h00040, 32'h0, 4'h0);
        step(9);
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(5);
        checkOutput("t4_grant_cnt", 64'(grants.size() - g0), 64'd3);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t4_grant_id", 64'(grants[g0+k].id), 64'd0);
            checkOutput("t4_grant_cyc", 64'(grants[g0+k].cyc - grants[g0].cyc), 64'(4 * k));
        end

        // Reset during the second access cycle of an m0 read
        r0 = resps.size();
        applyStimulus(0, 1'b1, 1'b0, 20'h00050, 32'h0, 4'h0);
        step(1);
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        checkOutput("t5_en_after_rst", 64'(io_sram_en), 64'h0);
        step(3);
        checkOutput("t5_no_resp", 64'(resps.size() - r0), 64'd0);
        g1 = grants.size();
        applyStimulus(0, 1'b1, 1'b0, 20'h00051, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 20'h00061, 32'h0, 4'h0);
        step(1);
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(6);
        checkOutput("t5_grant_cnt", 64'(grants.size() - g1), 64'd1);
        checkOutput("t5_first_winner", 64'(grants[g1].id), 64'd0);

        // m1 pulses valid for one cycle during m0's access and is dropped
        sram_dout = 32'h600DCAFE;
        g0 = grants.size(); a0 = accs.size();
        applyStimulus(0, 1'b1, 1'b0, 20'h00055, 32'h0, 4'h0);
        step(1);
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b1, 20'h00066, 32'h99999999, 4'hF);
        step(1);
        applyStimulus(1, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(6);
        n1 = 0;
        for (int k = g0; k < grants.size(); k++) if (grants[k].id == 1) n1++;
        checkOutput("t6_m1_grants", 64'(n1), 64'd0);
        checkOutput("t6_grant_cnt", 64'(grants.size() - g0), 64'd1);
        checkOutput("t6_acc_cnt", 64'(accs.size() - a0), 64'd2);
        checkOutput("t6_acc_addr", 64'({accs[a0].addr, accs[a0+1].addr}), 64'({20'h00055, 20'h00055}));

        // m0 write keeps m0's previous read data
        sram_dout = 32'hFFFFFFFF;
        r0 = resps.size();
        applyStimulus(0, 1'b1, 1'b1, 20'h00077, 32'h11112222, 4'hC);
        step(1);
        applyStimulus(0, 1'b0, 1'b0, 20'h0, 32'h0, 4'h0);
        step(5);
        checkOutput("t7_resp_id", 64'(resps[r0].id), 64'd0);
        checkOutput("t7_rdata_held", 64'(resps[r0].rdata), 64'h600DCAFE);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
